// File: rtl/pokey_pkg.sv
// Shared definitions for the POKEY channel countdown timer.
package pokey_pkg;

    localparam int unsigned TIMER_WIDTH = 8;

    typedef enum logic {
        COUNTING    = 1'b0,
        WAIT_RELOAD = 1'b1
    } timer_state_e;

endpackage

// File: rtl/pokey_countdown_timer.sv
// POKEY channel down-counter: underflow pulse feeds the external delay_line, reload returns from it.
// Optional latched interrupt output is built when POKEY_TIMER_IRQ_EN is defined.
module pokey_countdown_timer
    import pokey_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             force_load,
    input  logic             reload,
    output logic             data_out,
    output logic [WIDTH-1:0] count,
    input  logic             irq_enable,
    input  logic             irq_clear,
    output logic             irq_n
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] audf_q, audf_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             pulse_q, pulse_d;
    logic             underflow;

    always_comb begin
        state_d   = state_q;
        audf_d    = audf_q;
        count_d   = count_q;
        pulse_d   = pulse_q;
        underflow = 1'b0;
        if (ce) begin
            pulse_d = 1'b0;
            if (wr_en) begin
                audf_d = data_in;
            end
            if (force_load) begin
                count_d = wr_en ? data_in : audf_q;
                state_d = COUNTING;
            end else if (reload) begin
                count_d = audf_q;
                state_d = COUNTING;
            end else if (enable && (state_q == COUNTING)) begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    // One pulse per reload; WAIT_RELOAD blocks re-triggering at zero.
                    underflow = 1'b1;
                    pulse_d   = 1'b1;
                    state_d   = WAIT_RELOAD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= COUNTING;
            audf_q  <= '0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            audf_q  <= audf_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign data_out = pulse_q;
    assign count    = count_q;

`ifdef POKEY_TIMER_IRQ_EN
    logic irq_n_q, irq_n_d;

    // Set takes priority over acknowledge in the same cycle.
    always_comb begin
        irq_n_d = irq_n_q;
        if (ce) begin
            if (underflow && irq_enable) begin
                irq_n_d = 1'b0;
            end else if (irq_clear || !irq_enable) begin
                irq_n_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;
`else
    logic unused_irq;
    assign unused_irq = irq_enable ^ irq_clear ^ underflow;
    assign irq_n      = 1'b1;
`endif

endmodule

// File: tb/tb_pokey_countdown_timer.sv
// Randomized and directed bench for pokey_countdown_timer against a behavioural channel model.
module tb_pokey_countdown_timer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         ce = 1'b0;
    logic         enable = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         force_load = 1'b0;
    logic         reload = 1'b0;
    logic         data_out;
    logic [W-1:0] count;
    logic         irq_enable = 1'b0;
    logic         irq_clear = 1'b0;
    logic         irq_n;

    pokey_countdown_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .enable     (enable),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .force_load (force_load),
        .reload     (reload),
        .data_out   (data_out),
        .count      (count),
        .irq_enable (irq_enable),
        .irq_clear  (irq_clear),
        .irq_n      (irq_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural channel: latch, counter, "already fired" flag, pulse, irq, one-stage return path.
    int unsigned m_audf, m_count;
    bit          m_fired, m_pulse, m_irq_n, m_ret;
    bit          auto_reload = 1'b0;
    int unsigned spur_pct = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_audf = 0; m_count = 0; m_fired = 0; m_pulse = 0; m_irq_n = 1; m_ret = 0;
    endtask

    task automatic model_step();
        bit fire;
        if (!ce) return;
        fire = 0;
        if (force_load) begin
            m_count = wr_en ? int'(data_in) : m_audf;
            m_fired = 0;
        end else if (reload) begin
            m_count = m_audf;
            m_fired = 0;
        end else if (enable && !m_fired) begin
            if (m_count > 0) m_count = m_count - 1;
            else begin
                fire    = 1;
                m_fired = 1;
            end
        end
        if (wr_en) m_audf = int'(data_in);
`ifdef POKEY_TIMER_IRQ_EN
        if (fire && irq_enable) m_irq_n = 0;
        else if (irq_clear || !irq_enable) m_irq_n = 1;
`endif
        m_ret   = m_pulse;
        m_pulse = fire;
    endtask

    // Reload returns one ce cycle after the pulse, so period = AUDF+1 ticks + 2.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("count", 32'(count), 32'(m_count));
        check_eq("data_out", 32'(data_out), 32'(m_pulse));
        check_eq("irq_n", 32'(irq_n), 32'(m_irq_n));
        if (auto_reload) reload = m_ret | ($urandom_range(0, 99) < spur_pct);
    endtask

    task automatic load(input logic [W-1:0] v);
        wr_en = 1; data_in = v; force_load = 1;
        tick();
        wr_en = 0; force_load = 0;
    endtask

    int  last, pulses;
    bit  prev, found;

    initial begin
        model_reset();
        #12;
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_data_out", 32'(data_out), 0);
        check_eq("rst_irq_n", 32'(irq_n), 1);
        @(negedge clk);
        reset_n = 1;
        ce = 1;

        // AUDF=3 with enable every cycle and the return path closed.
        load(8'd3);
        check_eq("load3", 32'(count), 3);
        enable = 1; auto_reload = 1;
        last = -1; prev = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i < 3) check_eq("seq", 32'(count), 32'(2 - i));
            check_eq("single_pulse", 32'(prev & data_out), 0);
            if (data_out) begin
                if (last >= 0) check_eq("period4", 32'(i - last), 6);
                last = i;
            end
            prev = data_out;
        end

        // AUDF=0: shortest period, never two consecutive high cycles.
        load(8'd0);
        last = -1; prev = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("single_pulse0", 32'(prev & data_out), 0);
            if (data_out) begin
                if (last >= 0) check_eq("period1", 32'(i - last), 3);
                last = i;
            end
            prev = data_out;
        end

        // No reload: exactly one underflow, count parked at zero.
        auto_reload = 0; reload = 0;
        load(8'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (data_out) pulses++;
        end
        check_eq("one_pulse", 32'(pulses), 1);
        check_eq("parked", 32'(count), 0);

        // Write, STIMER and reload together: new value wins.
        enable = 0;
        wr_en = 1; data_in = 8'h11;
        tick();
        data_in = 8'h55; force_load = 1; reload = 1;
        tick();
        check_eq("same_cycle_cnt", 32'(count), 32'h55);
        check_eq("same_cycle_do", 32'(data_out), 0);
        wr_en = 0; reload = 0;
        tick();
        check_eq("audf_kept", 32'(count), 32'h55);
        force_load = 0;

        // ce low freezes the counter, then asynchronous reset mid-count.
        load(8'h20);
        enable = 1; ce = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("frozen", 32'(count), 32'h20);
        end
        ce = 1;
        #2 reset_n = 0;
        #1;
        check_eq("async_count", 32'(count), 0);
        check_eq("async_do", 32'(data_out), 0);
        model_reset();
        #2 reset_n = 1;
        reload = 0;

`ifdef POKEY_TIMER_IRQ_EN
        auto_reload = 1; irq_enable = 1; irq_clear = 1;
        load(8'd1);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            found = data_out;
        end
        check_eq("irq_seen", 32'(found), 1);
        check_eq("irq_set_wins", 32'(irq_n), 0);
        tick();
        check_eq("irq_cleared", 32'(irq_n), 1);
        irq_clear = 0;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            found = data_out;
        end
        check_eq("irq_seen2", 32'(found), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("irq_held", 32'(irq_n), 0);
        end
        irq_clear = 1;
        tick();
        check_eq("irq_ack", 32'(irq_n), 1);
        irq_clear = 0;
`endif

        // Randomized traffic with occasional spurious reloads.
        auto_reload = 1; spur_pct = 3;
        for (int i = 0; i < 500; i++) begin
            ce         = ($urandom_range(0, 99) < 85);
            enable     = ($urandom_range(0, 99) < 60);
            wr_en      = ($urandom_range(0, 99) < 8);
            data_in    = W'($urandom_range(0, 6));
            force_load = ($urandom_range(0, 99) < 3);
            irq_enable = ($urandom_range(0, 99) < 80);
            irq_clear  = ($urandom_range(0, 99) < 15);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
